lcrc_arbiter: RTL and testbench
===============================

# lcrc_arbiter

Sequencer and two-way arbiter in front of the shared `crc` LCRC engine on the link-layer transmit path. It grants the engine to one of two requesters: requester 0 is the replay buffer and requester 1 is new-TLP transmit. For each packet it clears the engine, streams the packet's 208-bit blocks through it with `crc_en`, then captures the final 32-bit LCRC and reports it with the source ID. Only one packet is in the engine at a time, and a grant holds until that packet's last block.

## Interface
- `DATA_W`, 208: block width fed to the engine.
- `CRC_W`, 32: LCRC width.
- `CRC_LAT`, 1: cycles from a `crc_en` cycle to the matching valid `crc_res`; legal range 1..7.
- `MAX_BLK`, 16: maximum blocks per packet before forced termination.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester block valid.
- `req_last`  in  2  per-requester last-block flag, qualified by `req_valid`.
- `req_data0`  in  DATA_W  requester 0 block.
- `req_data1`  in  DATA_W  requester 1 block.
- `req_ready`  out  2  per-requester accept; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `crc_data`  out  DATA_W  block to engine.
- `crc_en`  out  1  engine enable; high exactly on transfer cycles.
- `crc_clr`  out  1  engine clear/seed, one-cycle pulse.
- `crc_res`  in  CRC_W  engine result.
- `lcrc_out`  out  CRC_W  captured LCRC.
- `lcrc_valid`  out  1  one-cycle result strobe.
- `lcrc_src`  out  1  requester that owns `lcrc_out`.
- `lcrc_err`  out  1  qualified by `lcrc_valid`; high when the packet was cut at `MAX_BLK`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset values:
  - State is IDLE and the round-robin pointer favours requester 0.
  - All outputs are 0: `req_ready`, `crc_en`, `crc_clr`, `crc_data`, `lcrc_*`, `busy`.
- FSM states are IDLE, CLEAR, FEED, WAIT, DONE.
- IDLE:
  - If any `req_valid` is high, latch the winner into `grant` and go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR:
  - `crc_clr` = 1 for one cycle.
  - Block counter reset to 0.
  - Go to FEED.
- FEED:
  - `req_ready[grant]` = 1 and the other ready bit = 0.
  - `crc_data` is combinationally muxed from `req_data[grant]`.
  - `crc_en` = `req_valid[grant]`.
  - A `req_valid` gap leaves the state in FEED with `crc_en` = 0.
  - Each transfer increments the counter.
  - Go to WAIT on a transfer with `req_last` = 1, or on the transfer that makes the count equal `MAX_BLK` (sets the sticky `err`).
- WAIT:
  - Counts CRC_LAT cycles, then registers `crc_res` into `lcrc_out` and goes to DONE.
- DONE:
  - `lcrc_valid` = 1, `lcrc_src` = `grant`, `lcrc_err` = `err`.
  - Clear `err`, update the round-robin pointer, go to IDLE.
- `lcrc_out` holds its value until the next capture.
- The non-granted requester is never acknowledged. Its `req_valid` may stay high indefinitely.
- After a forced cut, the remaining blocks of the cut packet are arbitrated as a new packet; discarding them is the requester's job.
- `crc_data` is 0 whenever `crc_en` is 0.

## Timing
- The grant decision happens in cycle T in IDLE. `crc_clr` is high in T+1, and the earliest transfer is T+2.
- Last transfer in cycle N gives:
  - `lcrc_out` loaded at the end of cycle N+CRC_LAT;
  - `lcrc_valid` high in cycle N+CRC_LAT+1;
  - back in IDLE at N+CRC_LAT+2.
- Packet-to-packet gap is 3 + CRC_LAT cycles with no feed: CLEAR, WAIT×CRC_LAT, DONE, IDLE.
- Simultaneous `req_valid` in IDLE: the winner is set by the configuration below. Only the `req_valid` sampled in IDLE matters.
- Reset asserted mid-packet:
  - All outputs go to 0 immediately, asynchronously.
  - No `lcrc_valid` is issued for the aborted packet.
  - The engine is re-seeded by the next CLEAR.
- A 1-block packet with last set finishes FEED in one cycle.

## Configuration
- `LCRC_ARB_RR_EN` defined: round-robin.
  - After a DONE for requester i, the pointer favours requester 1−i.
  - On simultaneous requests, the favoured requester wins.
  - A lone requester always wins, regardless of the pointer.
- Not defined: fixed priority.
  - Requester 0 (replay) always wins simultaneous requests.
  - The pointer register is not implemented.

## Test plan
- Reset release, requester 1 alone, 3 blocks with last on the third, CRC_LAT = 1:
  - `crc_clr` 1 cycle after grant, then `crc_en` on 3 consecutive cycles.
  - `lcrc_valid` 2 cycles after the last transfer, with `lcrc_src` = 1, `lcrc_err` = 0 and `lcrc_out` equal to the engine result for the 3 blocks.
- Both requesters valid in IDLE, 1-block packets each, back-to-back:
  - With RR: grants 0, 1, 0, 1.
  - Without RR: grants 0, 0, 0 while requester 0 keeps requesting.
- `req_valid[grant]` dropped for 2 cycles mid-packet:
  - `crc_en` = 0 during the gap, no extra counter increment, LCRC is unchanged versus the gapless run.
- Packet of `MAX_BLK`+2 blocks with MAX_BLK = 4:
  - Cut after the 4th transfer, `lcrc_valid` with `lcrc_err` = 1.
  - The 5th block starts a new packet with a fresh `crc_clr`.
- `rst` asserted low during FEED on block 2:
  - `req_ready`, `crc_en`, `busy` = 0 immediately and no `lcrc_valid` follows.
  - After release, the next request is granted with a new `crc_clr`.
- CRC_LAT = 3:
  - `lcrc_valid` exactly 4 cycles after the last transfer.

Source files
------------

// File: rtl/lcrc_arbiter.sv
// Two-way arbiter and sequencer in front of the shared LCRC engine.
// Define LCRC_ARB_RR_EN for round-robin; otherwise replay (req 0) has fixed priority.
module lcrc_arbiter #(
    parameter int DATA_W  = 208,
    parameter int CRC_W   = 32,
    parameter int CRC_LAT = 1,
    parameter int MAX_BLK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_last,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] crc_data,
    output logic              crc_en,
    output logic              crc_clr,
    input  logic [CRC_W-1:0]  crc_res,
    output logic [CRC_W-1:0]  lcrc_out,
    output logic              lcrc_valid,
    output logic              lcrc_src,
    output logic              lcrc_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BLK + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             grant;
    logic             win;
    logic             err;
    logic [CNT_W-1:0] blk_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       lat_cnt;
    logic             xfer;
    logic             last_g;
    logic             hit_max;
    logic             lat_done;

    assign xfer     = (state == FEED) && req_valid[grant];
    assign last_g   = req_last[grant];
    assign cnt_inc  = blk_cnt + CNT_W'(1);
    assign hit_max  = (cnt_inc == CNT_W'(MAX_BLK));
    assign lat_done = (lat_cnt == 3'(CRC_LAT - 1));
    assign busy     = (state != IDLE);
    assign crc_data = crc_en ? (grant ? req_data1 : req_data0) : '0;

`ifdef LCRC_ARB_RR_EN
    logic prio;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        win = req_valid[1];
        if (&req_valid) begin
            win = prio;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
        end else if (state == DONE) begin
            prio <= ~grant;
        end
    end
`else
    always_comb begin
        win = ~req_valid[0];
    end
`endif

    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        lcrc_valid = 1'b0;
        lcrc_src   = 1'b0;
        lcrc_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                crc_clr  = 1'b1;
                state_nx = FEED;
            end
            FEED: begin
                req_ready[grant] = 1'b1;
                crc_en           = req_valid[grant];
                if (xfer && (last_g || hit_max)) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (lat_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                lcrc_valid = 1'b1;
                lcrc_src   = grant;
                lcrc_err   = err;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            err      <= 1'b0;
            blk_cnt  <= '0;
            lat_cnt  <= '0;
            lcrc_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req_valid) begin
                grant <= win;
            end
            if (state == CLEAR) begin
                blk_cnt <= '0;
            end else if (xfer) begin
                blk_cnt <= cnt_inc;
            end
            // A packet that ends on its own last flag is not a cut.
            if (xfer && hit_max && !last_g) begin
                err <= 1'b1;
            end else if (state == DONE) begin
                err <= 1'b0;
            end
            if (state == WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end else begin
                lat_cnt <= '0;
            end
            if (state == WAIT && lat_done) begin
                lcrc_out <= crc_res;
            end
        end
    end

endmodule

// File: tb/tb_lcrc_arbiter.sv
// Randomized bench for lcrc_arbiter with a timeline reference model
// and a stand-in LCRC engine; directed scenarios pin the model.
module tb_lcrc_arbiter;

    localparam int DW   = 208;
    localparam int CW   = 32;
    localparam int LAT  = 3;
    localparam int MAXB = 4;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_last;
    logic [DW-1:0] req_data0;
    logic [DW-1:0] req_data1;
    logic [1:0]    req_ready;
    logic [DW-1:0] crc_data;
    logic          crc_en;
    logic          crc_clr;
    logic [CW-1:0] crc_res;
    logic [CW-1:0] lcrc_out;
    logic          lcrc_valid;
    logic          lcrc_src;
    logic          lcrc_err;
    logic          busy;

    lcrc_arbiter #(
        .DATA_W (DW),
        .CRC_W  (CW),
        .CRC_LAT(LAT),
        .MAX_BLK(MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .crc_data  (crc_data),
        .crc_en    (crc_en),
        .crc_clr   (crc_clr),
        .crc_res   (crc_res),
        .lcrc_out  (lcrc_out),
        .lcrc_valid(lcrc_valid),
        .lcrc_src  (lcrc_src),
        .lcrc_err  (lcrc_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [DW-1:0] d);
        logic [31:0] x;
        x = {a[30:0], a[31]};
        for (int k = 0; k < 6; k++) x = x ^ d[k*32 +: 32];
        x = x ^ {16'h0, d[207:192]};
        return x * 32'h9E37_79B1 + 32'h7F4A_7C15;
    endfunction

    // Engine stand-in: result of a crc_en cycle appears LAT cycles later.
    logic [31:0] eng [LAT];
    always_ff @(posedge clk) begin
        if (crc_clr) eng[0] <= SEED;
        else if (crc_en) eng[0] <= mix(eng[0], crc_data);
        for (int k = 1; k < LAT; k++) eng[k] <= eng[k-1];
    end
    assign crc_res = eng[LAT-1];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] qd0[$];
    logic [DW-1:0] qd1[$];
    bit ql0[$];
    bit ql1[$];
    bit acc0, acc1;
    int pause0, pause1;
    int pval;

    bit m_act, m_g, m_end, m_err, m_prio;
    int m_tg, m_tl, m_cnt;
    logic [31:0] m_acc, m_out;

    int clr_q[$];
    int en_q[$];
    int ev_cyc[$];
    bit ev_src[$];
    bit ev_err[$];
    logic [31:0] ev_out[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        clr_q.delete(); en_q.delete(); ev_cyc.delete();
        ev_src.delete(); ev_err.delete(); ev_out.delete();
    endtask

    function automatic logic [DW-1:0] rnd208();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic push_blk(input int i, input logic [DW-1:0] d, input bit l);
        if (i == 0) begin qd0.push_back(d); ql0.push_back(l); end
        else begin qd1.push_back(d); ql1.push_back(l); end
    endtask

    task automatic push_pkt(input int i, input int n);
        for (int k = 0; k < n; k++) push_blk(i, rnd208(), k == n - 1);
    endtask

    task automatic check_model();
        logic [1:0]    e_ready;
        logic          e_en, e_clr, e_busy, e_val;
        logic [DW-1:0] e_data, dg;
        logic          lg;
        cyc++;
        e_ready = '0; e_en = 0; e_clr = 0; e_busy = 0; e_val = 0; e_data = '0;
        dg = m_g ? req_data1 : req_data0;
        lg = req_last[m_g];
        if (!rst) begin
            m_act = 0; m_prio = 0; m_out = '0;
        end else if (m_act) begin
            e_busy = 1;
            if (cyc == m_tg + 1) e_clr = 1;
            else if (!m_end) begin
                e_ready[m_g] = 1'b1;
                e_en = req_valid[m_g];
                if (e_en) e_data = dg;
            end else if (cyc == m_tl + LAT + 1) e_val = 1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("crc_en", crc_en, e_en);
        chk("crc_clr", crc_clr, e_clr);
        chk("crc_data", crc_data, e_data);
        chk("busy", busy, e_busy);
        chk("lcrc_valid", lcrc_valid, e_val);
        chk("lcrc_out", lcrc_out, m_out);
        if (e_val) begin
            chk("lcrc_src", lcrc_src, m_g);
            chk("lcrc_err", lcrc_err, m_err);
        end
        if (crc_clr) clr_q.push_back(cyc);
        if (crc_en) en_q.push_back(cyc);
        if (lcrc_valid) begin
            ev_cyc.push_back(cyc); ev_src.push_back(lcrc_src);
            ev_err.push_back(lcrc_err); ev_out.push_back(lcrc_out);
        end
        if (rst) begin
            if (!m_act) begin
                if (req_valid != 2'b00) begin
`ifdef LCRC_ARB_RR_EN
                    m_g = (req_valid == 2'b11) ? m_prio : req_valid[1];
`else
                    m_g = !req_valid[0];
`endif
                    m_act = 1; m_tg = cyc; m_cnt = 0;
                    m_end = 0; m_err = 0; m_acc = SEED;
                end
            end else if (e_en) begin
                m_acc = mix(m_acc, dg);
                m_cnt++;
                if (lg || m_cnt == MAXB) begin
                    m_end = 1; m_tl = cyc; m_err = !lg;
                end
            end else if (m_end && cyc == m_tl + LAT) begin
                m_out = m_acc;
            end else if (e_val) begin
                m_act = 0; m_prio = !m_g;
            end
        end
    endtask

    task automatic step(input bit rst_mid);
        @(posedge clk);
        #1;
        if (acc0) begin qd0.delete(0); ql0.delete(0); end
        if (acc1) begin qd1.delete(0); ql1.delete(0); end
        if (pause0 > 0) begin req_valid[0] = 0; pause0--; end
        else req_valid[0] = (qd0.size() > 0) && ($urandom_range(99) < pval);
        if (pause1 > 0) begin req_valid[1] = 0; pause1--; end
        else req_valid[1] = (qd1.size() > 0) && ($urandom_range(99) < pval);
        req_data0   = (qd0.size() > 0) ? qd0[0] : '0;
        req_data1   = (qd1.size() > 0) ? qd1[0] : '0;
        req_last[0] = (ql0.size() > 0) ? ql0[0] : 1'b0;
        req_last[1] = (ql1.size() > 0) ? ql1[0] : 1'b0;
        rst = !rst_mid;
        @(negedge clk);
        check_model();
        acc0 = req_valid[0] & req_ready[0];
        acc1 = req_valid[1] & req_ready[1];
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((qd0.size() > 0 || qd1.size() > 0 || m_act) && n < budget) begin
            step(0);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s timeout: %0d cycles without going idle", nm, n);
        end
    endtask

    task automatic wait_en(input string nm, input int cnt);
        int n;
        n = 0;
        while (en_q.size() < cnt && n < 40) begin step(0); n++; end
        chk(nm, en_q.size(), cnt);
    endtask

    initial begin
        logic [DW-1:0] b [6];
        logic [31:0]   out_a;
        bit [3:0]      want;
        rst = 0; req_valid = '0; req_last = '0;
        req_data0 = '0; req_data1 = '0;
        acc0 = 0; acc1 = 0; pause0 = 0; pause1 = 0; pval = 100;
        m_act = 0; m_g = 0; m_end = 0; m_err = 0; m_prio = 0;
        m_tg = 0; m_tl = 0; m_cnt = 0; m_acc = SEED; m_out = '0;
        for (int k = 0; k < 6; k++) b[k] = rnd208();
        repeat (3) step(1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_lcrc_out", lcrc_out, 32'h0);
        step(0);

        // Requester 1 alone, three blocks.
        clear_logs();
        for (int k = 0; k < 3; k++) push_blk(1, b[k], k == 2);
        drain("d1", 60);
        chk("d1_clr_n", clr_q.size(), 1);
        chk("d1_en_n", en_q.size(), 3);
        chk("d1_ev_n", ev_cyc.size(), 1);
        if (clr_q.size() == 1 && en_q.size() == 3 && ev_cyc.size() == 1) begin
            chk("d1_clr_to_en", en_q[0] - clr_q[0], 1);
            chk("d1_en_span", en_q[2] - en_q[0], 2);
            chk("d1_last_to_valid", ev_cyc[0] - en_q[2], 4);
            chk("d1_src", ev_src[0], 1'b1);
            chk("d1_err", ev_err[0], 1'b0);
            chk("d1_out", ev_out[0], mix(mix(mix(SEED, b[0]), b[1]), b[2]));
        end

        // Both requesters, one-block packets back to back.
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            push_blk(0, b[k], 1'b1);
            push_blk(1, b[k+1], 1'b1);
        end
`ifdef LCRC_ARB_RR_EN
        want = 4'b1010;
`else
        want = 4'b0000;
`endif
        drain("d2", 200);
        chk("d2_ev_n", ev_cyc.size(), 8);
        for (int k = 0; k < 4 && k < ev_src.size(); k++)
            chk($sformatf("d2_grant%0d", k), ev_src[k], want[k]);

        // Gapless versus gapped packet on requester 0.
        clear_logs();
        for (int k = 0; k < 3; k++) push_blk(0, b[k], k == 2);
        drain("d3a", 60);
        out_a = lcrc_out;
        chk("d3_gapless_out", out_a, mix(mix(mix(SEED, b[0]), b[1]), b[2]));
        clear_logs();
        for (int k = 0; k < 3; k++) push_blk(0, b[k], k == 2);
        wait_en("d3_first_en", 1);
        pause0 = 2;
        drain("d3b", 60);
        chk("d3_en_n", en_q.size(), 3);
        chk("d3_ev_n", ev_cyc.size(), 1);
        if (en_q.size() == 3 && ev_cyc.size() == 1) begin
            chk("d3_gap", en_q[1] - en_q[0], 3);
            chk("d3_out", ev_out[0], out_a);
            chk("d3_err", ev_err[0], 1'b0);
        end

        // MAX_BLK + 2 blocks: forced cut after four.
        clear_logs();
        for (int k = 0; k < 6; k++) push_blk(0, b[k], k == 5);
        drain("d4", 100);
        chk("d4_ev_n", ev_cyc.size(), 2);
        chk("d4_clr_n", clr_q.size(), 2);
        chk("d4_en_n", en_q.size(), 6);
        if (ev_cyc.size() == 2) begin
            chk("d4_err0", ev_err[0], 1'b1);
            chk("d4_err1", ev_err[1], 1'b0);
            chk("d4_out0", ev_out[0],
                mix(mix(mix(mix(SEED, b[0]), b[1]), b[2]), b[3]));
            chk("d4_out1", ev_out[1], mix(mix(SEED, b[4]), b[5]));
        end

        // Reset during FEED while block 2 is offered.
        clear_logs();
        for (int k = 0; k < 3; k++) push_blk(0, b[k], k == 2);
        wait_en("d5_first_en", 1);
        step(1);
        chk("d5_ready", req_ready, 2'b00);
        chk("d5_en", crc_en, 1'b0);
        chk("d5_busy", busy, 1'b0);
        chk("d5_valid", lcrc_valid, 1'b0);
        drain("d5", 60);
        chk("d5_ev_n", ev_cyc.size(), 1);
        chk("d5_clr_n", clr_q.size(), 2);
        if (ev_cyc.size() == 1) begin
            chk("d5_out", ev_out[0], mix(mix(SEED, b[1]), b[2]));
            chk("d5_err", ev_err[0], 1'b0);
        end

        // Randomized traffic with occasional resets.
        pval = 70;
        for (int it = 0; it < 3000; it++) begin
            if (qd0.size() < 3 && $urandom_range(7) == 0) push_pkt(0, $urandom_range(1, 6));
            if (qd1.size() < 3 && $urandom_range(7) == 0) push_pkt(1, $urandom_range(1, 6));
            if (it % 500 == 250) pval = $urandom_range(40, 100);
            step($urandom_range(599) == 0);
        end
        pval = 100;
        drain("random", 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
